uart_cmd_framer: RTL and testbench

UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

---
 rtl/uart_cmd_framer.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_framer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_framer (with uart_byte_core)
// Purpose  : Collects CMD_BYTES serial bytes into a command word and sends a
//            RESP_BYTES response word MSB byte first, on top of a byte UART.
// Options  : define CMD_TIMEOUT_EN to discard a partial command after
//            TIMEOUT_CLKS idle clocks between bytes (pulses rx_to).
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// uart_byte_core: 8N1 byte UART, BAUD_DIV clocks per bit.
// rx_rdy is sticky until clr_rx_rdy; tx_done is sticky until the next trmt.
// ----------------------------------------------------------------------------
module uart_byte_core #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);
    localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

    logic          rx_meta_q, rx_sync_q, rx_busy_q, rx_rdy_q;
    logic [BW-1:0] rx_baud_q;
    logic [3:0]    rx_bits_q;
    logic [7:0]    rx_shift_q;

    logic [8:0]    tx_shift_q;
    logic [BW-1:0] tx_baud_q;
    logic [3:0]    tx_bits_q;
    logic          tx_busy_q, tx_done_q;

    // Receiver: synchronise RX, find the start edge, sample each bit mid-cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_rdy_q   <= 1'b0;
            rx_baud_q  <= '0;
            rx_bits_q  <= 4'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BAUD_HALF;
                    rx_bits_q <= 4'd0;
                end
            end else if (rx_baud_q == BAUD_LAST) begin
                rx_baud_q <= '0;
                rx_bits_q <= rx_bits_q + 4'd1;
                if (rx_bits_q == 4'd0) begin
                    // line back high at mid start bit: treat as a glitch
                    if (rx_sync_q) rx_busy_q <= 1'b0;
                end else if (rx_bits_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    if (rx_sync_q) rx_rdy_q <= 1'b1;
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                end
            end else begin
                rx_baud_q <= rx_baud_q + 1'b1;
            end
        end
    end

    // Transmitter: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q <= 9'h1FF;
            tx_baud_q  <= '0;
            tx_bits_q  <= 4'd0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else if (trmt) begin
            tx_shift_q <= {tx_data, 1'b0};
            tx_baud_q  <= '0;
            tx_bits_q  <= 4'd0;
            tx_busy_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BAUD_LAST) begin
                tx_baud_q  <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                if (tx_bits_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end else begin
                    tx_bits_q <= tx_bits_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + 1'b1;
            end
        end
    end

    assign rx_data = rx_shift_q;
    assign rx_rdy  = rx_rdy_q;
    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;
endmodule

// ----------------------------------------------------------------------------
// uart_cmd_framer: command assembly (RX) and response sequencing (TX).
// ----------------------------------------------------------------------------
module uart_cmd_framer #(
    parameter int CMD_BYTES    = 2,
    parameter int RESP_BYTES   = 1,
    parameter int TIMEOUT_CLKS = 500000,
    parameter int BAUD_DIV     = 434
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RX,
    output logic                    TX,
    output logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    cmd_rdy,
    input  logic                    clr_cmd_rdy,
    output logic                    cmd_ovf,
    input  logic                    trmt,
    input  logic [8*RESP_BYTES-1:0] resp,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    rx_to
);
    localparam int CW = 8 * CMD_BYTES;
    localparam int RW = 8 * RESP_BYTES;
    localparam int IW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int OW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
    localparam logic [IW-1:0] CMD_LAST  = IW'(CMD_BYTES - 1);
    localparam logic [OW-1:0] RESP_LAST = OW'(RESP_BYTES - 1);

    if (CMD_BYTES < 1 || CMD_BYTES > 8 || RESP_BYTES < 1 || RESP_BYTES > 8 ||
        TIMEOUT_CLKS < 2 || BAUD_DIV < 1) begin : g_bad_params
        $error("uart_cmd_framer: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_t;

    logic [7:0]    core_rx_data;
    logic          core_rx_rdy;
    logic          core_tx_done;

    logic [CW-1:0] cmd_q, cmd_d;
    logic [IW-1:0] idx_q;
    logic          cmd_rdy_q, cmd_ovf_q, unread_q;

    tx_state_t     state_q;
    logic [RW-1:0] resp_q;
    logic [OW-1:0] tx_idx_q;
    logic          core_trmt_q, tx_busy_q, tx_done_q;
    logic [7:0]    core_tx_data_q;

    uart_byte_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .clk        (clk),
        .rst_n      (~rst),
        .RX         (RX),
        .TX         (TX),
        .rx_data    (core_rx_data),
        .rx_rdy     (core_rx_rdy),
        .clr_rx_rdy (core_rx_rdy),
        .trmt       (core_trmt_q),
        .tx_data    (core_tx_data_q),
        .tx_done    (core_tx_done)
    );

    // New bytes enter at the LSB end so the first byte ends up on top.
    assign cmd_d = (cmd_q << 8) | CW'(core_rx_data);

`ifdef CMD_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
    logic [TW-1:0] to_cnt_q;
    logic          rx_to_q;
`endif

    // Command assembly. unread_q remembers a completed command that has not
    // been acknowledged with clr_cmd_rdy; it outlives cmd_rdy (which drops as
    // soon as the next command starts overwriting cmd) so that a completion
    // on top of an unacknowledged command is reported as an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q     <= '0;
            idx_q     <= '0;
            cmd_rdy_q <= 1'b0;
            cmd_ovf_q <= 1'b0;
            unread_q  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            to_cnt_q  <= '0;
            rx_to_q   <= 1'b0;
`endif
        end else begin
            cmd_ovf_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            rx_to_q   <= 1'b0;
`endif
            if (core_rx_rdy) begin
                cmd_q <= cmd_d;
`ifdef CMD_TIMEOUT_EN
                to_cnt_q <= '0;
`endif
                if (idx_q == CMD_LAST) begin
                    idx_q     <= '0;
                    cmd_rdy_q <= 1'b1;
                    unread_q  <= 1'b1;
                    cmd_ovf_q <= unread_q & ~clr_cmd_rdy;
                end else begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == '0 || clr_cmd_rdy) cmd_rdy_q <= 1'b0;
                    if (clr_cmd_rdy) unread_q <= 1'b0;
                end
            end else begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_q <= 1'b0;
                    unread_q  <= 1'b0;
                end
`ifdef CMD_TIMEOUT_EN
                if (idx_q != '0) begin
                    if (to_cnt_q == TO_LAST) begin
                        to_cnt_q <= '0;
                        idx_q    <= '0;
                        rx_to_q  <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end else begin
                    to_cnt_q <= '0;
                end
`endif
            end
        end
    end

    // Response sequencer. The core's tx_done is sticky from the previous
    // byte and only clears once it sees trmt, so WAIT ignores it on the
    // cycle the trmt pulse is still being presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            resp_q         <= '0;
            tx_idx_q       <= '0;
            core_trmt_q    <= 1'b0;
            core_tx_data_q <= 8'd0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    core_trmt_q <= 1'b0;
                    if (trmt) begin
                        resp_q    <= resp;
                        tx_idx_q  <= '0;
                        tx_done_q <= 1'b0;
                        tx_busy_q <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    core_trmt_q    <= 1'b1;
                    core_tx_data_q <= resp_q[RW-1 -: 8];
                    state_q        <= WAIT;
                end
                WAIT: begin
                    core_trmt_q <= 1'b0;
                    if (!core_trmt_q && core_tx_done) begin
                        if (tx_idx_q == RESP_LAST) begin
                            tx_done_q <= 1'b1;
                            tx_busy_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                            resp_q   <= resp_q << 8;
                            state_q  <= LOAD;
                        end
                    end
                end
                default: begin
                    core_trmt_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign cmd_ovf = cmd_ovf_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;
`ifdef CMD_TIMEOUT_EN
    assign rx_to   = rx_to_q;
`else
    assign rx_to   = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_framer
// Purpose  : Self-checking bench for uart_cmd_framer (CMD_BYTES=2,
//            RESP_BYTES=2). Honours CMD_TIMEOUT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_framer;
    localparam int CMD_BYTES    = 2;
    localparam int RESP_BYTES   = 2;
    localparam int TIMEOUT_CLKS = 1000;
    localparam int BAUD_DIV     = 16;
    localparam int CW           = 8 * CMD_BYTES;
    localparam int RW           = 8 * RESP_BYTES;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          RX = 1'b1;
    logic          clr_cmd_rdy = 1'b0;
    logic          trmt = 1'b0;
    logic [RW-1:0] resp = '0;
    logic          TX, cmd_rdy, cmd_ovf, tx_busy, tx_done, rx_to;
    logic [CW-1:0] cmd;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    uart_cmd_framer #(
        .CMD_BYTES    (CMD_BYTES),
        .RESP_BYTES   (RESP_BYTES),
        .TIMEOUT_CLKS (TIMEOUT_CLKS),
        .BAUD_DIV     (BAUD_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_ovf     (cmd_ovf),
        .trmt        (trmt),
        .resp        (resp),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .rx_to       (rx_to)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference for the command side ----------
    byte unsigned  sent_q[$];   // bytes put on RX, not yet delivered
    byte unsigned  part_q[$];   // bytes of the command being collected
    logic [CW-1:0] m_cmd    = '0;
    bit            m_rdy    = 0;
    bit            m_unread = 0;
    bit            m_ovf    = 0;
    bit            m_rto    = 0;
    int            m_idle   = 0;
    int            ovf_seen = 0;
    int            rto_seen = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            part_q.delete();
            m_cmd = '0; m_rdy = 0; m_unread = 0; m_ovf = 0; m_rto = 0; m_idle = 0;
        end else begin
            m_ovf = 0;
            m_rto = 0;
            if (dut.core_rx_rdy) begin
                m_idle = 0;
                if (sent_q.size() == 0) begin
                    check("rx_unexpected_byte", 64'd1, 64'd0);
                end else begin
                    check("rx_byte", 64'(dut.core_rx_data), 64'(sent_q[0]));
                    part_q.push_back(sent_q.pop_front());
                end
                if (part_q.size() == CMD_BYTES) begin
                    m_cmd = '0;
                    foreach (part_q[i]) m_cmd = m_cmd * 256 + CW'(part_q[i]);
                    part_q.delete();
                    m_ovf    = m_unread && !clr_cmd_rdy;
                    m_rdy    = 1;
                    m_unread = 1;
                end else begin
                    if (part_q.size() == 1) m_rdy = 0;
                    if (clr_cmd_rdy) begin m_rdy = 0; m_unread = 0; end
                end
            end else begin
                if (clr_cmd_rdy) begin m_rdy = 0; m_unread = 0; end
`ifdef CMD_TIMEOUT_EN
                if (part_q.size() > 0) begin
                    m_idle++;
                    if (m_idle >= TIMEOUT_CLKS) begin
                        part_q.delete();
                        m_rto  = 1;
                        m_idle = 0;
                    end
                end
`endif
            end
        end
    end

    // Per-cycle comparison of the command-side outputs and reset values.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_cmd", 64'(cmd), 64'd0);
            check("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
            check("rst_cmd_ovf", 64'(cmd_ovf), 64'd0);
            check("rst_rx_to", 64'(rx_to), 64'd0);
            check("rst_tx_busy", 64'(tx_busy), 64'd0);
            check("rst_tx_done", 64'(tx_done), 64'd0);
            check("rst_TX", 64'(TX), 64'd1);
        end else begin
            check("cmd_rdy", 64'(cmd_rdy), 64'(m_rdy));
            check("cmd_ovf", 64'(cmd_ovf), 64'(m_ovf));
            check("rx_to", 64'(rx_to), 64'(m_rto));
            if (m_rdy) check("cmd", 64'(cmd), 64'(m_cmd));
            check("tx_busy_and_done", 64'(tx_busy & tx_done), 64'd0);
            if (cmd_ovf) ovf_seen++;
            if (rx_to) rto_seen++;
        end
    end

    // ---------------- serial decoder on TX ----------------
    byte unsigned txd_q[$];
    initial begin : tx_decoder
        bit         abort;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) begin
                abort = 0;
                d     = 8'd0;
                repeat (BAUD_DIV / 2) begin @(negedge clk); if (rst) abort = 1; end
                if (TX !== 1'b0) abort = 1;
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) begin @(negedge clk); if (rst) abort = 1; end
                    d[i] = TX;
                end
                repeat (BAUD_DIV) begin @(negedge clk); if (rst) abort = 1; end
                if (!abort) begin
                    check("tx_stop_bit", 64'(TX), 64'd1);
                    txd_q.push_back(d);
                end
                while (TX !== 1'b1) @(negedge clk);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        sent_q.push_back(b);
        RX = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BAUD_DIV) @(negedge clk);
    endtask

    task automatic send_resp(input logic [RW-1:0] r, input bit poke_mid);
        int cyc;
        txd_q.delete();
        check("tx_busy_before", 64'(tx_busy), 64'd0);
        resp = r;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        resp = RW'($urandom);   // must not disturb the latched word
        check("tx_busy_start", 64'(tx_busy), 64'd1);
        check("tx_done_start", 64'(tx_done), 64'd0);
        for (cyc = 0; cyc < 40 * BAUD_DIV * RESP_BYTES && !tx_done; cyc++) begin
            check("tx_busy_inflight", 64'(tx_busy), 64'd1);
            trmt = poke_mid && (cyc == 3 * BAUD_DIV);
            if (trmt) resp = ~r;
            @(negedge clk);
        end
        trmt = 1'b0;
        if (!tx_done) check("tx_done_timeout", 64'd0, 64'd1);
        else          check("tx_busy_end", 64'(tx_busy), 64'd0);
        check("tx_frame_count", 64'(txd_q.size()), 64'(RESP_BYTES));
        for (int i = 0; i < RESP_BYTES && i < txd_q.size(); i++)
            check("tx_byte", 64'(txd_q[i]), 64'(r[RW-1-8*i -: 8]));
        txd_q.delete();
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    bit rand_rx_done;
    initial begin : main
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd", 64'(cmd), 64'd0);
        check("post_rst_TX", 64'(TX), 64'd1);

        // Two-byte command, no overflow.
        send_byte(8'hA5);
        send_byte(8'h3C);
        check("lit_cmd_A53C", 64'(cmd), 64'h A53C);
        check("lit_rdy_A53C", 64'(cmd_rdy), 64'd1);
        check("lit_no_ovf", 64'(ovf_seen), 64'd0);
        pulse_clr();

        // Overflow on an unacknowledged command.
        ovf_seen = 0;
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        check("lit_cmd_3344", 64'(cmd), 64'h3344);
        check("lit_one_ovf", 64'(ovf_seen), 64'd1);

        // clr_cmd_rdy coincident with completion leaves cmd_rdy set.
        send_byte(8'h66);
        fork
            send_byte(8'h77);
            begin
                for (int i = 0; i < 20 * BAUD_DIV && !dut.core_rx_rdy; i++) @(negedge clk);
                if (!dut.core_rx_rdy) check("clr_sync_timeout", 64'd0, 64'd1);
                else pulse_clr();
            end
        join
        check("lit_rdy_after_clr", 64'(cmd_rdy), 64'd1);
        check("lit_cmd_6677", 64'(cmd), 64'h6677);

        // Two-byte response with an ignored second request.
        send_resp(16'hBEEF, 1'b1);
        repeat (20 * BAUD_DIV) @(negedge clk);
        check("lit_no_extra_frame", 64'(txd_q.size()), 64'd0);
        check("lit_tx_done_sticky", 64'(tx_done), 64'd1);
        check("lit_tx_idle_high", 64'(TX), 64'd1);

        // Partial command followed by a long idle gap.
        pulse_clr();
        rto_seen = 0;
        send_byte(8'h55);
        repeat (TIMEOUT_CLKS + 20) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        check("lit_one_rx_to", 64'(rto_seen), 64'd1);
        check("lit_rdy_kept_low", 64'(cmd_rdy), 64'd0);
`else
        check("lit_no_rx_to", 64'(rto_seen), 64'd0);
        send_byte(8'h99);
        check("lit_cmd_5599", 64'(cmd), 64'h5599);
`endif
        send_byte(8'h12); send_byte(8'h34);
        check("lit_cmd_1234", 64'(cmd), 64'h1234);

        // Reset mid-command and mid-response.
        send_byte(8'hAB);
        resp = 16'hC3A5;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (5 * BAUD_DIV) @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("lit_rst_busy", 64'(tx_busy), 64'd0);
        check("lit_rst_rdy", 64'(cmd_rdy), 64'd0);
        send_byte(8'hC0); send_byte(8'hDE);
        check("lit_cmd_C0DE", 64'(cmd), 64'hC0DE);
        check("lit_rst_no_frames", 64'(txd_q.size()), 64'd0);
        check("lit_tx_high_after_rst", 64'(TX), 64'd1);
        txd_q.delete();

        // Randomised concurrent traffic.
        rand_rx_done = 0;
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    send_byte(8'($urandom));
                    repeat ($urandom_range(0, 40)) @(negedge clk);
                end
                repeat (4) @(negedge clk);
                rand_rx_done = 1;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    send_resp(RW'($urandom), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(1, 60)) @(negedge clk);
                end
            end
            begin
                while (!rand_rx_done) begin
                    clr_cmd_rdy = ($urandom_range(0, 31) == 0);
                    @(negedge clk);
                end
                clr_cmd_rdy = 1'b0;
            end
        join
        check("rand_all_bytes_delivered", 64'(sent_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
